// File: rtl/seg_scroll_pkg.sv
// Shared definitions for the scrolling seven-segment message controller.
package seg_scroll_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL,
        DONE
    } state_t;

    localparam int unsigned DISPLAY_DIGITS = 8;
    localparam int unsigned BLANK_W        = $clog2(DISPLAY_DIGITS);

endpackage

// File: rtl/scroll_tick_gen.sv
// Free-running period counter producing a one-cycle tick every PERIOD cycles.
module scroll_tick_gen #(
    parameter int unsigned PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == CW'(PERIOD - 1));

endmodule

// File: rtl/seg_scroll_controller.sv
// Buffers hex nibbles and scrolls them through an 8-digit shift display,
// followed by a blank trailer, optionally looping.
module seg_scroll_controller
    import seg_scroll_pkg::*;
#(
    parameter real         CLK_FREQ    = 100.0,
    parameter real         SCROLL_RATE = 4.0,
    parameter int unsigned MSG_DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         msg_wr,
    input  logic [3:0]                   msg_data,
    input  logic                         msg_clr,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop,
    output logic                         busy,
    output logic                         done,
    output logic                         msg_full,
    output logic [$clog2(MSG_DEPTH):0]   msg_count,
    output logic [3:0]                   seg_data,
    output logic                         seg_off,
    output logic                         seg_write,
    output logic                         seg_shift,
    output logic                         seg_clear
);

    localparam int          TICK_CYCLES = int'(CLK_FREQ * 1.0e6 / SCROLL_RATE);
    localparam int unsigned CW          = $clog2(MSG_DEPTH) + 1;
    localparam int unsigned AW          = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

    if (TICK_CYCLES < 2) begin : g_tick_check
        $error("seg_scroll_controller: TICK_CYCLES must be at least 2");
    end

    state_t               state, state_next;
    logic [CW-1:0]        idx;
    logic [BLANK_W-1:0]   blank_cnt;
    logic                 loop_q;
    logic                 tick;
    logic [3:0]           msg_buf [MSG_DEPTH];

    logic                 start_ok, wr_ok, data_push, last_blank;
    logic                 push, clear_d, seg_off_d;
    logic [3:0]           seg_data_d;

    assign msg_full   = (msg_count == CW'(MSG_DEPTH));
    assign start_ok   = (state == IDLE) && start && !stop && (msg_count != '0);
    assign wr_ok      = (state == IDLE) && msg_wr && !msg_clr && !msg_full;
    assign data_push  = (idx < msg_count);
    assign last_blank = (blank_cnt == BLANK_W'(DISPLAY_DIGITS - 1));

    // Restarting on the accepted start makes the CLEAR cycle count zero, so the
    // first push lands TICK_CYCLES cycles after the seg_clear pulse.
    scroll_tick_gen #(
        .PERIOD (TICK_CYCLES)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (start_ok),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            seg_data  <= '0;
            seg_off   <= 1'b0;
            seg_write <= 1'b0;
            seg_shift <= 1'b0;
            seg_clear <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
            seg_data  <= seg_data_d;
            seg_off   <= seg_off_d;
            seg_write <= push;
            seg_shift <= push;
            seg_clear <= clear_d;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_ok) state_next = CLEAR;
            CLEAR:   state_next = SCROLL;
            SCROLL:  if (push && !data_push && last_blank && !loop_q) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (stop && state != IDLE) state_next = IDLE;
    end

    always_comb begin
        push       = (state == SCROLL) && tick && !stop;
        clear_d    = start_ok || (stop && state != IDLE);
        seg_data_d = '0;
        seg_off_d  = 1'b0;
        if (push) begin
            if (data_push) seg_data_d = msg_buf[idx[AW-1:0]];
            else           seg_off_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            blank_cnt <= '0;
            loop_q    <= 1'b0;
            msg_count <= '0;
        end else begin
            if (start_ok) loop_q <= loop;
            if (state == CLEAR) begin
                idx       <= '0;
                blank_cnt <= '0;
            end else if (push) begin
                if (data_push) begin
                    idx <= idx + CW'(1);
                end else if (last_blank) begin
                    idx       <= '0;
                    blank_cnt <= '0;
                end else begin
                    blank_cnt <= blank_cnt + BLANK_W'(1);
                end
            end
            if (state == IDLE && msg_clr) msg_count <= '0;
            else if (wr_ok)               msg_count <= msg_count + CW'(1);
        end
    end

    // Contents are never cleared; msg_count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) msg_buf[msg_count[AW-1:0]] <= msg_data;
    end

endmodule

// File: doc/seg_scroll_controller.md
SEG_SCROLL_CONTROLLER -- requirements
Module: seg_scroll_controller

Interface
REQ-001 Parameter CLK_FREQ, default 100, real, clock frequency in MHz.
REQ-002 Parameter SCROLL_RATE, default 4, real, scroll steps per second.
REQ-003 Parameter MSG_DEPTH, default 16, message buffer depth in nibbles.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 msg_wr  in  1  append msg_data to the message buffer.
REQ-007 msg_data  in  4  hex nibble to append.
REQ-008 msg_clr  in  1  empty the message buffer.
REQ-009 start  in  1  begin scrolling the buffered message.
REQ-010 stop  in  1  abort scrolling.
REQ-011 loop  in  1  repeat the message, sampled with start.
REQ-012 busy  out  1  high while not IDLE.
REQ-013 done  out  1  one-cycle pulse on normal completion.
REQ-014 msg_full  out  1  buffer holds MSG_DEPTH nibbles.
REQ-015 msg_count  out  $clog2(MSG_DEPTH)+1  nibbles buffered.
REQ-016 seg_data  out  4  nibble to the display driver.
REQ-017 seg_off  out  1  pushed digit is blank.
REQ-018 seg_write  out  1  display write strobe.
REQ-019 seg_shift  out  1  display shift strobe.
REQ-020 seg_clear  out  1  display clear strobe.

Function
REQ-021 TICK_CYCLES = CLK_FREQ*1e6/SCROLL_RATE; elaboration SHALL fail if TICK_CYCLES < 2.
REQ-022 FSM states: IDLE, CLEAR, SCROLL, DONE.
REQ-023 IDLE: start with msg_count>0 SHALL latch loop, enter CLEAR; start with msg_count=0 SHALL be ignored.
REQ-024 CLEAR: seg_clear high exactly one cycle (cycle after start sampled); read index, blank counter, tick counter reset to 0; next state SCROLL.
REQ-025 SCROLL: each tick SHALL produce one cycle with seg_write=seg_shift=1; first tick TICK_CYCLES cycles after the seg_clear cycle, then every TICK_CYCLES.
REQ-026 Per tick: while read index < msg_count, seg_data=buffer[index], seg_off=0, index++; afterwards 8 blank pushes with seg_off=1, seg_data=0.
REQ-027 After the 8th blank: loop latched -> index and blank counter to 0, stay SCROLL with uninterrupted tick cadence; else enter DONE.
REQ-028 DONE: done high one cycle, then IDLE.
REQ-029 stop in CLEAR/SCROLL/DONE SHALL, next cycle, pulse seg_clear, suppress pending strobes, go IDLE, no done; stop has priority over tick and start.
REQ-030 Strobes and seg_data/seg_off SHALL be registered; seg_data=0, seg_off=0 outside push cycles.
REQ-031 msg_wr accepted only in IDLE and when not full; otherwise dropped silently.
REQ-032 msg_clr accepted only in IDLE; msg_clr with msg_wr same cycle: clear wins, count=0.
REQ-033 Buffer contents SHALL be preserved across a scroll, so start may replay them.

Reset
REQ-034 rst SHALL immediately force IDLE, msg_count=0, and busy, done, msg_full, seg_data, seg_off, seg_write, seg_shift, seg_clear all 0.
REQ-035 Reset mid-scroll SHALL discard the buffer and abandon the scroll without a seg_clear pulse.

Structure
REQ-036 Shared package seg_scroll_pkg SHALL hold the state enum, DISPLAY_DIGITS=8 and the blank-count width.
REQ-037 Tick generation SHALL be one sub-module scroll_tick_gen (period parameter, synchronous restart input, one-cycle tick output).

Verification (bench CLK_FREQ=1, SCROLL_RATE=250000 -> TICK_CYCLES=4)
REQ-038 Load 1,2,3; start loop=0 -> seg_clear at cycle 1; pushes at 5,9,13 carry 1,2,3 seg_off=0; 8 blank pushes at 17..45; done once; busy falls after done.
REQ-039 Load A,B; start loop=1 -> A,B, 8 blanks, A at 4-cycle spacing; stop mid -> seg_clear next cycle, busy=0, no done.
REQ-040 Write 17 nibbles -> msg_full after the 16th, msg_count=16, 17th dropped; msg_wr and msg_clr same cycle -> msg_count=0.
REQ-041 start with empty buffer -> no strobes, busy stays 0; msg_wr while busy -> msg_count unchanged.
REQ-042 Assert rst asynchronously between ticks mid-scroll -> all outputs 0 before the next clk edge, msg_count=0.
